// File: rtl/data_path_pkg.sv
// Shared constants and types for the single-bus datapath slice.
// Optional ALU add function is enabled with DATAPATH_ALU_ADD_EN.
package data_path_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 7;

    // Bit positions of the bus drive selects; a higher index wins when several are set.
    localparam int SEL_R3  = 0;
    localparam int SEL_R2  = 1;
    localparam int SEL_R1  = 2;
    localparam int SEL_PC  = 3;
    localparam int SEL_ZHI = 4;
    localparam int SEL_ZLO = 5;
    localparam int SEL_MDR = 6;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_MDR,
        SRC_ZLO,
        SRC_ZHI,
        SRC_PC,
        SRC_R1,
        SRC_R2,
        SRC_R3
    } bus_src_e;

    typedef logic [2*DATA_W-1:0] product_t;

    function automatic bus_src_e pick_source(input logic [SEL_W-1:0] sel);
        if (sel[SEL_MDR])      return SRC_MDR;
        else if (sel[SEL_ZLO]) return SRC_ZLO;
        else if (sel[SEL_ZHI]) return SRC_ZHI;
        else if (sel[SEL_PC])  return SRC_PC;
        else if (sel[SEL_R1])  return SRC_R1;
        else if (sel[SEL_R2])  return SRC_R2;
        else if (sel[SEL_R3])  return SRC_R3;
        else                   return SRC_NONE;
    endfunction

endpackage

// File: rtl/data_path_if.sv
// Control/observation bundle between the control unit (master) and the datapath (slave).
// The ADD strobe exists only when DATAPATH_ALU_ADD_EN is defined.
interface data_path_if;
    import data_path_pkg::*;

    logic [DATA_W-1:0] Mdatain;
    logic              MD_read;
    logic              MDRin, MARin, PCin, IRin, Yin;
    logic              R1in, R2in, R3in;
    logic              Zlowin, Zhighin;
    logic              IncPC;
`ifdef DATAPATH_ALU_ADD_EN
    logic              ADD;
`endif
    logic              PCout, MDRout, Zlowout, Zhighout, R1out, R2out, R3out;
    logic [DATA_W-1:0] BusMuxOut;
    logic [DATA_W-1:0] MAR_q, IR_q, PC_q;

    modport master (
`ifdef DATAPATH_ALU_ADD_EN
        output ADD,
`endif
        output Mdatain, MD_read,
        output MDRin, MARin, PCin, IRin, Yin, R1in, R2in, R3in, Zlowin, Zhighin,
        output IncPC,
        output PCout, MDRout, Zlowout, Zhighout, R1out, R2out, R3out,
        input  BusMuxOut, MAR_q, IR_q, PC_q
    );

    modport slave (
`ifdef DATAPATH_ALU_ADD_EN
        input  ADD,
`endif
        input  Mdatain, MD_read,
        input  MDRin, MARin, PCin, IRin, Yin, R1in, R2in, R3in, Zlowin, Zhighin,
        input  IncPC,
        input  PCout, MDRout, Zlowout, Zhighout, R1out, R2out, R3out,
        output BusMuxOut, MAR_q, IR_q, PC_q
    );

endinterface

// File: rtl/data_path_dp_reg.sv
// Load-enable register with synchronous active-low clear; clear beats the enable.
module dp_reg
    import data_path_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] val_d, val_q;

    always_comb begin
        val_d = val_q;
        if (en) val_d = d;
    end

    always_ff @(posedge clock) begin
        if (!clear) val_q <= '0;
        else        val_q <= val_d;
    end

    assign q = val_q;

endmodule

// File: rtl/data_path.sv
// Single-bus CPU datapath: priority bus mux, increment/signed-multiply ALU and register file.
// Defining DATAPATH_ALU_ADD_EN adds a Y+bus ALU function selected by ADD.
module data_path
    import data_path_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    data_path_if.slave dp
);

    logic [DATA_W-1:0] pc_q, ir_q, mar_q, mdr_q, y_q, zhi_q, zlo_q, r1_q, r2_q, r3_q;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] mdr_d;
    logic [SEL_W-1:0]  drive_sel;
    bus_src_e          bus_src;
    product_t          alu_result;

    always_comb begin
        drive_sel          = '0;
        drive_sel[SEL_MDR] = dp.MDRout;
        drive_sel[SEL_ZLO] = dp.Zlowout;
        drive_sel[SEL_ZHI] = dp.Zhighout;
        drive_sel[SEL_PC]  = dp.PCout;
        drive_sel[SEL_R1]  = dp.R1out;
        drive_sel[SEL_R2]  = dp.R2out;
        drive_sel[SEL_R3]  = dp.R3out;
        bus_src            = pick_source(drive_sel);
        bus                = '0;
        case (bus_src)
            SRC_MDR: bus = mdr_q;
            SRC_ZLO: bus = zlo_q;
            SRC_ZHI: bus = zhi_q;
            SRC_PC:  bus = pc_q;
            SRC_R1:  bus = r1_q;
            SRC_R2:  bus = r2_q;
            SRC_R3:  bus = r3_q;
            default: bus = '0;
        endcase
    end

    // Low half of the product of sign-extended operands equals the signed 64-bit product.
    always_comb begin
        alu_result = {{DATA_W{y_q[DATA_W-1]}}, y_q} * {{DATA_W{bus[DATA_W-1]}}, bus};
`ifdef DATAPATH_ALU_ADD_EN
        if (dp.ADD) alu_result = {{DATA_W{1'b0}}, y_q + bus};
`endif
        if (dp.IncPC) alu_result = {{DATA_W{1'b0}}, bus + DATA_W'(1)};
    end

    always_comb begin
        mdr_d = bus;
        if (dp.MD_read) mdr_d = dp.Mdatain;
    end

    dp_reg #(.W(DATA_W)) u_pc  (.clock(clock), .clear(clear), .en(dp.PCin),    .d(bus),   .q(pc_q));
    dp_reg #(.W(DATA_W)) u_ir  (.clock(clock), .clear(clear), .en(dp.IRin),    .d(bus),   .q(ir_q));
    dp_reg #(.W(DATA_W)) u_mar (.clock(clock), .clear(clear), .en(dp.MARin),   .d(bus),   .q(mar_q));
    dp_reg #(.W(DATA_W)) u_mdr (.clock(clock), .clear(clear), .en(dp.MDRin),   .d(mdr_d), .q(mdr_q));
    dp_reg #(.W(DATA_W)) u_y   (.clock(clock), .clear(clear), .en(dp.Yin),     .d(bus),   .q(y_q));
    dp_reg #(.W(DATA_W)) u_r1  (.clock(clock), .clear(clear), .en(dp.R1in),    .d(bus),   .q(r1_q));
    dp_reg #(.W(DATA_W)) u_r2  (.clock(clock), .clear(clear), .en(dp.R2in),    .d(bus),   .q(r2_q));
    dp_reg #(.W(DATA_W)) u_r3  (.clock(clock), .clear(clear), .en(dp.R3in),    .d(bus),   .q(r3_q));
    dp_reg #(.W(DATA_W)) u_zlo (.clock(clock), .clear(clear), .en(dp.Zlowin),
                                .d(alu_result[DATA_W-1:0]), .q(zlo_q));
    dp_reg #(.W(DATA_W)) u_zhi (.clock(clock), .clear(clear), .en(dp.Zhighin),
                                .d(alu_result[2*DATA_W-1:DATA_W]), .q(zhi_q));

    assign dp.BusMuxOut = bus;
    assign dp.MAR_q     = mar_q;
    assign dp.IR_q      = ir_q;
    assign dp.PC_q      = pc_q;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed vector table, mid-operation reset and a
// randomized run against a register-array reference model (honours DATAPATH_ALU_ADD_EN).
module tb_data_path;

    // Load-enable mask bits, also used as register indices in the reference model.
    localparam int M_MDR = 0, M_MAR = 1, M_PC = 2, M_IR = 3, M_Y = 4;
    localparam int M_R1 = 5, M_R2 = 6, M_R3 = 7, M_ZLO = 8, M_ZHI = 9;
    localparam logic [9:0] LD_MDR = 10'h001, LD_MAR = 10'h002, LD_PC = 10'h004, LD_IR = 10'h008;
    localparam logic [9:0] LD_Y = 10'h010, LD_R1 = 10'h020, LD_R2 = 10'h040, LD_R3 = 10'h080;
    localparam logic [9:0] LD_ZLO = 10'h100, LD_ZHI = 10'h200;
    localparam logic [6:0] DR_R3 = 7'h01, DR_R2 = 7'h02, DR_R1 = 7'h04, DR_PC = 7'h08;
    localparam logic [6:0] DR_ZHI = 7'h10, DR_ZLO = 7'h20, DR_MDR = 7'h40;
    localparam int NV = 30;

    typedef struct {
        string       name;
        logic [31:0] mdatain;
        logic        md_read;
        logic        inc;
        logic [9:0]  ld;
        logic [6:0]  drv;
        logic [31:0] exp_bus;
        logic [31:0] exp_mar;
        logic [31:0] exp_ir;
        logic [31:0] exp_pc;
    } vec_t;

    logic clock = 1'b0;
    logic clear;
    int   tests = 0;
    int   failures = 0;
    vec_t vecs[NV];
    logic [31:0] m[10];

    data_path_if dpif();

    data_path dut (
        .clock(clock),
        .clear(clear),
        .dp   (dpif)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(string n, logic [31:0] md, logic rd, logic inc, logic [9:0] ld,
                                logic [6:0] drv, logic [31:0] eb, logic [31:0] em,
                                logic [31:0] ei, logic [31:0] ep);
        vec_t v;
        v.name = n; v.mdatain = md; v.md_read = rd; v.inc = inc; v.ld = ld; v.drv = drv;
        v.exp_bus = eb; v.exp_mar = em; v.exp_ir = ei; v.exp_pc = ep;
        return v;
    endfunction

    task automatic applyStimulus(input logic [31:0] md, input logic rd, input logic inc,
                                 input logic add, input logic [9:0] ld, input logic [6:0] drv,
                                 input logic clr);
        clear         = clr;
        dpif.Mdatain  = md;
        dpif.MD_read  = rd;
        dpif.IncPC    = inc;
`ifdef DATAPATH_ALU_ADD_EN
        dpif.ADD      = add;
`else
        if (add) dpif.IncPC = inc;
`endif
        dpif.MDRin    = ld[M_MDR];
        dpif.MARin    = ld[M_MAR];
        dpif.PCin     = ld[M_PC];
        dpif.IRin     = ld[M_IR];
        dpif.Yin      = ld[M_Y];
        dpif.R1in     = ld[M_R1];
        dpif.R2in     = ld[M_R2];
        dpif.R3in     = ld[M_R3];
        dpif.Zlowin   = ld[M_ZLO];
        dpif.Zhighin  = ld[M_ZHI];
        dpif.R3out    = drv[0];
        dpif.R2out    = drv[1];
        dpif.R1out    = drv[2];
        dpif.PCout    = drv[3];
        dpif.Zhighout = drv[4];
        dpif.Zlowout  = drv[5];
        dpif.MDRout   = drv[6];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Register selected by each drive strobe, listed from highest to lowest bus priority.
    function automatic logic [31:0] model_bus(input logic [6:0] drv);
        int order_bit[7] = '{6, 5, 4, 3, 2, 1, 0};
        int order_reg[7] = '{M_MDR, M_ZLO, M_ZHI, M_PC, M_R1, M_R2, M_R3};
        for (int k = 0; k < 7; k++)
            if (drv[order_bit[k]]) return m[order_reg[k]];
        return 32'h0;
    endfunction

    task automatic model_step(input logic [31:0] md, input logic rd, input logic inc,
                              input logic add, input logic [9:0] ld, input logic [31:0] bus);
        longint      prod;
        int          ys, bs;
        logic [63:0] res;
        ys = m[M_Y];
        bs = bus;
        prod = longint'(ys) * longint'(bs);
        res = prod;
        if (add) res = {32'h0, m[M_Y] + bus};
        if (inc) res = {32'h0, bus + 32'd1};
        for (int r = 0; r < 10; r++) begin
            if (ld[r]) begin
                if (r == M_MDR)      m[r] = rd ? md : bus;
                else if (r == M_ZLO) m[r] = res[31:0];
                else if (r == M_ZHI) m[r] = res[63:32];
                else                 m[r] = bus;
            end
        end
    endtask

    initial begin
        logic [31:0] md, exp_bus;
        logic [9:0]  ld;
        logic [6:0]  drv;
        logic        rd, inc, add, clr;

        vecs[0]  = mk("mdr_ld12",    32'h12,       1, 0, LD_MDR, 7'h0, 32'h0,        32'h0, 32'h0, 32'h0);
        vecs[1]  = mk("r2_from_mdr", 32'h0,        0, 0, LD_R2,  DR_MDR, 32'h12,     32'h0, 32'h0, 32'h0);
        vecs[2]  = mk("mdr_ldm13",   32'hFFFFFFF3, 1, 0, LD_MDR, 7'h0, 32'h0,        32'h0, 32'h0, 32'h0);
        vecs[3]  = mk("r3_from_mdr", 32'h0,        0, 0, LD_R3,  DR_MDR, 32'hFFFFFFF3, 32'h0, 32'h0, 32'h0);
        vecs[4]  = mk("y_from_r2",   32'h0,        0, 0, LD_Y,   DR_R2, 32'h12,      32'h0, 32'h0, 32'h0);
        vecs[5]  = mk("mul",         32'h0,        0, 0, LD_ZLO | LD_ZHI, DR_R3, 32'hFFFFFFF3, 32'h0, 32'h0, 32'h0);
        vecs[6]  = mk("r1_from_zlo", 32'h0,        0, 0, LD_R1,  DR_ZLO, 32'hFFFFFF16, 32'h0, 32'h0, 32'h0);
        vecs[7]  = mk("zhi_out",     32'h0,        0, 0, 10'h0,  DR_ZHI, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
        vecs[8]  = mk("mar_from_r1", 32'h0,        0, 0, LD_MAR, DR_R1, 32'hFFFFFF16, 32'hFFFFFF16, 32'h0, 32'h0);
        vecs[9]  = mk("mdr_ld7",     32'h7,        1, 0, LD_MDR, 7'h0, 32'h0,        32'hFFFFFF16, 32'h0, 32'h0);
        vecs[10] = mk("pc_from_mdr", 32'h0,        0, 0, LD_PC,  DR_MDR, 32'h7,      32'hFFFFFF16, 32'h0, 32'h7);
        vecs[11] = mk("pc_inc",      32'h0,        0, 1, LD_MAR | LD_ZLO, DR_PC, 32'h7, 32'h7, 32'h0, 32'h7);
        vecs[12] = mk("pc_from_zlo", 32'h0,        0, 0, LD_PC,  DR_ZLO, 32'h8,      32'h7, 32'h0, 32'h8);
        vecs[13] = mk("mdr_ld6",     32'h6,        1, 0, LD_MDR, 7'h0, 32'h0,        32'h7, 32'h0, 32'h8);
        vecs[14] = mk("ir_from_mdr", 32'h0,        0, 0, LD_IR,  DR_MDR, 32'h6,      32'h7, 32'h6, 32'h8);
        vecs[15] = mk("prio_mdr",    32'h0,        0, 0, 10'h0,  DR_MDR | DR_R2, 32'h6, 32'h7, 32'h6, 32'h8);
        vecs[16] = mk("prio_zlo",    32'h0,        0, 0, 10'h0,  DR_ZLO | DR_ZHI | DR_PC | DR_R1, 32'h8, 32'h7, 32'h6, 32'h8);
        vecs[17] = mk("prio_zhi",    32'h0,        0, 0, 10'h0,  DR_ZHI | DR_PC | DR_R3, 32'hFFFFFFFF, 32'h7, 32'h6, 32'h8);
        vecs[18] = mk("prio_pc",     32'h0,        0, 0, 10'h0,  DR_PC | DR_R1 | DR_R2, 32'h8, 32'h7, 32'h6, 32'h8);
        vecs[19] = mk("prio_r1",     32'h0,        0, 0, 10'h0,  DR_R1 | DR_R2 | DR_R3, 32'hFFFFFF16, 32'h7, 32'h6, 32'h8);
        vecs[20] = mk("prio_r2",     32'h0,        0, 0, 10'h0,  DR_R2 | DR_R3, 32'h12, 32'h7, 32'h6, 32'h8);
        vecs[21] = mk("mdr_ldF",     32'hFFFFFFFF, 1, 0, LD_MDR, 7'h0, 32'h0,        32'h7, 32'h6, 32'h8);
        vecs[22] = mk("pc_max",      32'h0,        0, 0, LD_PC,  DR_MDR, 32'hFFFFFFFF, 32'h7, 32'h6, 32'hFFFFFFFF);
        vecs[23] = mk("pc_wrap",     32'h0,        0, 1, LD_ZLO | LD_ZHI, DR_PC, 32'hFFFFFFFF, 32'h7, 32'h6, 32'hFFFFFFFF);
        vecs[24] = mk("wrap_zlo",    32'h0,        0, 0, LD_MAR, DR_ZLO | DR_R3, 32'h0, 32'h0, 32'h6, 32'hFFFFFFFF);
        vecs[25] = mk("wrap_zhi",    32'h0,        0, 0, 10'h0,  DR_ZHI | DR_R2, 32'h0, 32'h0, 32'h6, 32'hFFFFFFFF);
        vecs[26] = mk("mdr_from_bus", 32'hDEAD,    0, 0, LD_MDR, DR_R2, 32'h12,      32'h0, 32'h6, 32'hFFFFFFFF);
        vecs[27] = mk("mdr_ld_drv",  32'h55,       1, 0, LD_MDR, DR_MDR, 32'h12,     32'h0, 32'h6, 32'hFFFFFFFF);
        vecs[28] = mk("mdr_new",     32'h0,        0, 0, 10'h0,  DR_MDR, 32'h55,     32'h0, 32'h6, 32'hFFFFFFFF);
        vecs[29] = mk("no_drive",    32'h0,        0, 0, 10'h0,  7'h0, 32'h0,        32'h0, 32'h6, 32'hFFFFFFFF);

        // Power-up reset with every enable high must still leave all registers at zero.
        applyStimulus(32'hA5A5A5A5, 1, 1, 0, 10'h3FF, 7'h0, 0);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset/mar", dpif.MAR_q, 32'h0);
        checkOutput("reset/ir",  dpif.IR_q,  32'h0);
        checkOutput("reset/pc",  dpif.PC_q,  32'h0);
        @(negedge clock);
        for (int b = 0; b < 7; b++) begin
            drv = 7'h0;
            drv[b] = 1'b1;
            applyStimulus(32'h0, 0, 0, 0, 10'h0, drv, 1);
            #1 checkOutput($sformatf("reset/drv%0d", b), dpif.BusMuxOut, 32'h0);
        end

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            applyStimulus(vecs[i].mdatain, vecs[i].md_read, vecs[i].inc, 0, vecs[i].ld, vecs[i].drv, 1);
            #1 checkOutput({vecs[i].name, "/bus"}, dpif.BusMuxOut, vecs[i].exp_bus);
            @(posedge clock);
            #1;
            checkOutput({vecs[i].name, "/mar"}, dpif.MAR_q, vecs[i].exp_mar);
            checkOutput({vecs[i].name, "/ir"},  dpif.IR_q,  vecs[i].exp_ir);
            checkOutput({vecs[i].name, "/pc"},  dpif.PC_q,  vecs[i].exp_pc);
        end

        // Clear during a Zlowin cycle must win over the ALU result.
        @(negedge clock);
        applyStimulus(32'h0, 0, 1, 0, LD_ZLO, DR_MDR, 1);
        @(negedge clock);
        applyStimulus(32'h0, 0, 0, 0, 10'h0, DR_ZLO, 1);
        #1 checkOutput("midrst/zlo_before", dpif.BusMuxOut, 32'h56);
        @(negedge clock);
        applyStimulus(32'h0, 0, 1, 0, LD_ZLO | LD_PC | LD_MAR | LD_IR, DR_MDR, 0);
        @(posedge clock);
        #1;
        checkOutput("midrst/mar", dpif.MAR_q, 32'h0);
        checkOutput("midrst/ir",  dpif.IR_q,  32'h0);
        checkOutput("midrst/pc",  dpif.PC_q,  32'h0);
        @(negedge clock);
        applyStimulus(32'h0, 0, 0, 0, 10'h0, DR_ZLO, 1);
        #1 checkOutput("midrst/zlo_after", dpif.BusMuxOut, 32'h0);
        applyStimulus(32'h0, 0, 0, 0, 10'h0, DR_MDR, 1);
        #1 checkOutput("midrst/mdr_after", dpif.BusMuxOut, 32'h0);

        for (int r = 0; r < 10; r++) m[r] = 32'h0;
        for (int c = 0; c < 400; c++) begin
            md  = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
            rd  = 1'($urandom_range(0, 1));
            inc = ($urandom_range(0, 3) == 0);
`ifdef DATAPATH_ALU_ADD_EN
            add = 1'($urandom_range(0, 1));
`else
            add = 1'b0;
`endif
            ld  = 10'($urandom_range(0, 1023)) & 10'($urandom_range(0, 1023));
            drv = 7'($urandom & $urandom);
            clr = ($urandom_range(0, 31) != 0);
            @(negedge clock);
            applyStimulus(md, rd, inc, add, ld, drv, clr);
            exp_bus = model_bus(drv);
            #1 checkOutput($sformatf("rand%0d/bus", c), dpif.BusMuxOut, exp_bus);
            if (clr) model_step(md, rd, inc, add, ld, exp_bus);
            else     for (int r = 0; r < 10; r++) m[r] = 32'h0;
            @(posedge clock);
            #1;
            checkOutput($sformatf("rand%0d/mar", c), dpif.MAR_q, m[M_MAR]);
            checkOutput($sformatf("rand%0d/ir", c),  dpif.IR_q,  m[M_IR]);
            checkOutput($sformatf("rand%0d/pc", c),  dpif.PC_q,  m[M_PC]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- 32-bit single-bus CPU datapath slice: PC, IR, MAR, MDR, Y, Z (ZHI/ZLO) and general registers R1–R3 share one bus.
- Controlled cycle-by-cycle by an external control unit (or bench) through one-hot `*out` and `*in` strobes.
- ALU fixed at two functions: signed multiply (Y × bus) and increment (bus + 1) for PC advance.
- Sits between the control unit and memory; memory read data arrives on `Mdatain`.

Parameters:
- DATA_W, 32, datapath/bus width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  synchronous, active-low reset.
- Mdatain  in  32  memory read data.
- MD_read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- MDRin, MARin, PCin, IRin, Yin  in  1 each  register load enables.
- R1in, R2in, R3in  in  1 each  general register load enables.
- Zlowin, Zhighin  in  1 each  ZLO/ZHI load enables.
- IncPC  in  1  ALU select: 1 = bus+1, 0 = Y×bus.
- PCout, MDRout, Zlowout, Zhighout, R1out, R2out, R3out  in  1 each  bus drive selects.
- BusMuxOut  out  32  current bus value.
- MAR_q, IR_q, PC_q  out  32 each  register contents (memory address, decode, debug).

Behaviour:
- Bus is a combinational mux. Priority when several selects are high: MDRout > Zlowout > Zhighout > PCout > R1out > R2out > R3out.
- No select high → bus = 0.
- All control inputs must be driven; the control unit holds unused selects at 0.
- Register loads happen on the rising clock edge when the enable is 1; otherwise the register holds. Loads take effect next cycle.
- MDR: loads Mdatain when MD_read = 1, else loads the bus; load only when MDRin = 1.
- ALU is combinational.
  - IncPC = 1: result = {32'h0, bus + 1}, 32-bit wrap (0xFFFFFFFF → 0x00000000).
  - IncPC = 0: result = signed(Y) × signed(bus), full 64-bit product.
- ZLO ← result[31:0] when Zlowin = 1; ZHI ← result[63:32] when Zhighin = 1. Each enable is independent.
- Simultaneous load and drive of the same register is legal: the register drives its old value and captures the new value at the edge.
- Reset: clear = 0 at a rising edge sets every register (PC, IR, MAR, MDR, Y, ZHI, ZLO, R1–R3) to 0. Reset overrides all enables, including mid-sequence.
- Outputs MAR_q, IR_q, PC_q read 0 in the cycle after reset.
- No internal FSM; sequencing is owned by the controller. One bus transfer per cycle.

Optional Feature:
- DATAPATH_ALU_ADD_EN:
  - Defined: adds input `ADD` (1 bit). When ADD = 1 and IncPC = 0, result = {32'h0, Y + bus}.
  - ALU priority with the macro: IncPC > ADD > MUL.
  - Undefined: no `ADD` port; ALU is increment/multiply only.

Decomposition:
- Package `data_path_pkg`: DATA_W; bus-select priority order as named constants; 64-bit product typedef.
- One sub-module: `dp_reg`, a parameterised enable/sync-active-low-reset register, instantiated for every storage element.
- Bus mux and ALU stay inline in data_path.

Test Plan:
- Reset: hold clear = 0 for 2 cycles with all enables = 1 → all outputs/registers read 0 afterwards.
- MDR/register load:
  - Mdatain = 0x12, MD_read = 1, MDRin = 1 → MDR = 0x12.
  - Next cycle MDRout = 1, R2in = 1 → R2 = 0x00000012; BusMuxOut = 0x12 during the transfer.
- Signed multiply:
  - R2 = 0x12, R3 = 0xFFFFFFF3 (−13).
  - R2out + Yin → Y = 0x12.
  - R3out + Zlowin + Zhighin → ZLO = 0xFFFFFF16, ZHI = 0xFFFFFFFF.
  - Zlowout + R1in → R1 = 0xFFFFFF16.
- PC increment:
  - PC = 0x00000007; PCout + MARin + IncPC + Zlowin → MAR = 7, ZLO = 8.
  - Then Zlowout + PCin → PC = 8.
  - Wrap case: PC = 0xFFFFFFFF → ZLO = 0.
- Instruction fetch: Mdatain = 0x6, MD_read + MDRin; then MDRout + IRin → IR_q = 0x00000006.
- Bus priority and reset mid-operation:
  - MDRout and R2out high together → bus = MDR.
  - clear = 0 asserted during a Zlowin cycle → ZLO = 0, not the ALU result.
